// File: rtl/dff_arb_pkg.sv
// Shared types and sizing helpers for the round-robin register write arbiter.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_t;

  localparam int CNT_W = 4;

  // Pointer/select width; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               valid
);

  int               t;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the closest match to ptr wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    t     = 0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      t = int'(ptr) + i;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      idx = PTR_W'(t);
      if (req[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit flip-flop register.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [WIDTH-1:0]         qout
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_t       state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n, sel_q, sel_n, pick_sel;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n, ack_n;
  logic             load_en;
  logic [WIDTH-1:0] wd_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wd_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] after(input logic [PTR_W-1:0] s);
    return (s == PTR_W'(NUM_REQ - 1)) ? '0 : s + 1'b1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (pick_sel),
    .valid (pick_vld)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_q;
    cnt_n   = cnt;
    grant_n = grant;
    ack_n   = '0;
    load_en = 1'b0;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (pick_vld) begin
          sel_n   = pick_sel;
          grant_n = onehot(pick_sel);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (req[sel_q]) begin
          load_en = 1'b1;
          ack_n   = onehot(sel_q);
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
          state_n = LOCK;
        end else begin
          // Requester withdrew before the write: release without touching qout.
          grant_n = '0;
          ptr_n   = after(sel_q);
          state_n = IDLE;
        end
      end
      LOCK: begin
        if (cnt == '0) begin
          grant_n = '0;
          ptr_n   = after(sel_q);
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel_q <= '0;
      cnt   <= '0;
      grant <= '0;
      ack   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel_q <= sel_n;
      cnt   <= cnt_n;
      grant <= grant_n;
      ack   <= ack_n;
    end
  end

  // Shared storage register: loads only on a committed write.
  always_ff @(posedge clk) begin
    if (rst)          qout <= '0;
    else if (load_en) qout <= wd_arr[sel_q];
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Table-driven and randomized bench for dff_reg_arbiter (NUM_REQ=4, WIDTH=8, HOLD_CYCLES=2).
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   grant, ack;
  logic           busy;
  logic [W-1:0]   qout;

  int n_tests = 0;
  int n_fail  = 0;

  dff_reg_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .grant (grant),
    .ack   (ack),
    .busy  (busy),
    .qout  (qout)
  );

  always #5 clk = ~clk;

  // Reference model: a service is identified by its winner and by how many
  // edges have elapsed since it was granted (0 = grant cycle, 1..H = hold).
  bit         m_busy = 1'b0;
  int         m_win  = 0;
  int         m_off  = 0;
  int         m_ptr  = 0;
  logic [7:0] m_q    = 8'h00;

  task automatic model_edge(input bit r, input logic [3:0] rq, input logic [31:0] wd);
    if (r) begin
      m_busy = 1'b0; m_off = 0; m_ptr = 0; m_q = 8'h00;
    end else if (!m_busy) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (((rq >> ((m_ptr + k) % N)) & 4'd1) != 4'd0) begin
          m_win  = (m_ptr + k) % N;
          m_busy = 1'b1;
          m_off  = 0;
        end
      end
    end else if (m_off == 0) begin
      if (((rq >> m_win) & 4'd1) != 4'd0) begin
        m_q   = 8'(wd >> (m_win * 8));
        m_off = 1;
      end else begin
        m_busy = 1'b0;
        m_ptr  = (m_win + 1) % N;
      end
    end else if (m_off < H) begin
      m_off = m_off + 1;
    end else begin
      m_busy = 1'b0;
      m_ptr  = (m_win + 1) % N;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] rq, input logic [31:0] wd);
    rst = r; req = rq; wdata = wd;
    @(posedge clk);
    model_edge(r, rq, wd);
    #1;
  endtask

  task automatic sc(input string nm, input bit r, input logic [3:0] rq, input logic [31:0] wd,
                    input logic [3:0] g, input logic [3:0] a, input bit b, input logic [7:0] q);
    step(r, rq, wd);
    chk({nm, " grant"}, 32'(grant), 32'(g));
    chk({nm, " ack"},   32'(ack),   32'(a));
    chk({nm, " busy"},  32'(busy),  32'(b));
    chk({nm, " qout"},  32'(qout),  32'(q));
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [31:0] wd;
    logic [3:0] g;
    logic [3:0] a;
    bit         b;
    logic [7:0] q;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input logic [3:0] rq, input logic [31:0] wd,
                              input logic [3:0] g, input logic [3:0] a, input bit b, input logic [7:0] q);
    vec_t v;
    v.rst = r; v.req = rq; v.wd = wd; v.g = g; v.a = a; v.b = b; v.q = q;
    tbl.push_back(v);
  endfunction

  localparam logic [31:0] W_RR = 32'h13121110;
  localparam logic [31:0] W_A5 = 32'h1312A510;

  initial begin
    logic [7:0] q_prev;
    logic [3:0] oh;
    logic [3:0] eg, ea;
    int c;
    rst = 1'b1; req = '0; wdata = '0;

    // Reset with all requests pending
    add(1, 4'hF, W_RR, 4'h0, 4'h0, 0, 8'h00);
    add(1, 4'hF, W_RR, 4'h0, 4'h0, 0, 8'h00);
    // Single requester 1
    add(0, 4'b0010, W_A5, 4'b0010, 4'h0,    1, 8'h00);
    add(0, 4'b0010, W_A5, 4'b0010, 4'b0010, 1, 8'hA5);
    add(0, 4'b0000, W_A5, 4'b0010, 4'h0,    1, 8'hA5);
    add(0, 4'b0000, W_A5, 4'h0,    4'h0,    0, 8'hA5);
    // Contention from a fresh pointer
    add(1, 4'h0, W_RR, 4'h0, 4'h0, 0, 8'h00);
    q_prev = 8'h00;
    for (int gi = 0; gi < 5; gi++) begin
      c  = gi % N;
      oh = 4'(32'd1 << c);
      add(0, 4'hF, W_RR, oh,   4'h0, 1, q_prev);
      add(0, 4'hF, W_RR, oh,   oh,   1, 8'(8'h10 + c));
      add(0, 4'hF, W_RR, oh,   4'h0, 1, 8'(8'h10 + c));
      add(0, 4'hF, W_RR, 4'h0, 4'h0, 0, 8'(8'h10 + c));
      q_prev = 8'(8'h10 + c);
    end
    // Withdrawal by requester 2, then search resumes at 3
    add(0, 4'b0100, W_RR, 4'b0100, 4'h0,    1, 8'h10);
    add(0, 4'b0000, W_RR, 4'h0,    4'h0,    0, 8'h10);
    add(0, 4'b1001, W_RR, 4'b1000, 4'h0,    1, 8'h10);
    add(0, 4'b1001, W_RR, 4'b1000, 4'b1000, 1, 8'h13);
    add(0, 4'b0000, W_RR, 4'b1000, 4'h0,    1, 8'h13);
    add(0, 4'b0000, W_RR, 4'h0,    4'h0,    0, 8'h13);

    for (int i = 0; i < tbl.size(); i++)
      sc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].wd,
         tbl[i].g, tbl[i].a, tbl[i].b, tbl[i].q);

    // Reset in the first LOCK cycle, then pointer must restart at 0
    sc("mid_g",   0, 4'b0100, W_RR, 4'b0100, 4'h0,    1, 8'h13);
    sc("mid_w",   0, 4'b0100, W_RR, 4'b0100, 4'b0100, 1, 8'h12);
    sc("mid_rst", 1, 4'b0100, W_RR, 4'h0,    4'h0,    0, 8'h00);
    sc("rr_g2",   0, 4'b1100, W_RR, 4'b0100, 4'h0,    1, 8'h00);
    sc("rr_w2",   0, 4'b1100, W_RR, 4'b0100, 4'b0100, 1, 8'h12);
    sc("rr_l2",   0, 4'b1000, W_RR, 4'b0100, 4'h0,    1, 8'h12);
    sc("rr_i2",   0, 4'b1000, W_RR, 4'h0,    4'h0,    0, 8'h12);
    sc("rr_g3",   0, 4'b1000, W_RR, 4'b1000, 4'h0,    1, 8'h12);
    sc("rr_w3",   0, 4'b1000, W_RR, 4'b1000, 4'b1000, 1, 8'h13);
    sc("rr_l3",   0, 4'b0000, W_RR, 4'b1000, 4'h0,    1, 8'h13);
    sc("rr_i3",   0, 4'b0000, W_RR, 4'h0,    4'h0,    0, 8'h13);

    // Requester 3 arrives while requester 0 holds the register
    sc("late_rst", 1, 4'b0000, W_RR, 4'h0,    4'h0,    0, 8'h00);
    sc("late_g0",  0, 4'b0001, W_RR, 4'b0001, 4'h0,    1, 8'h00);
    sc("late_w0",  0, 4'b0001, W_RR, 4'b0001, 4'b0001, 1, 8'h10);
    sc("late_l0",  0, 4'b1000, W_RR, 4'b0001, 4'h0,    1, 8'h10);
    sc("late_i0",  0, 4'b1000, W_RR, 4'h0,    4'h0,    0, 8'h10);
    sc("late_g3",  0, 4'b1000, W_RR, 4'b1000, 4'h0,    1, 8'h10);
    sc("late_w3",  0, 4'b1000, W_RR, 4'b1000, 4'b1000, 1, 8'h13);
    sc("late_l3",  0, 4'b0000, W_RR, 4'b1000, 4'h0,    1, 8'h13);
    sc("late_i3",  0, 4'b0000, W_RR, 4'h0,    4'h0,    0, 8'h13);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 63) == 0, 4'($urandom), $urandom);
      eg = m_busy ? 4'(32'd1 << m_win) : 4'h0;
      ea = (m_busy && m_off == 1) ? 4'(32'd1 << m_win) : 4'h0;
      chk($sformatf("rnd%0d grant", i), 32'(grant), 32'(eg));
      chk($sformatf("rnd%0d ack", i),   32'(ack),   32'(ea));
      chk($sformatf("rnd%0d busy", i),  32'(busy),  32'(m_busy));
      chk($sformatf("rnd%0d qout", i),  32'(qout),  32'(m_q));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
